pst_trial_sequencer: RTL and testbench

PST_TRIAL_SEQUENCER -- requirements
Module: pst_trial_sequencer

---
 rtl/pst_seq_pkg.sv | 26 ++
 rtl/pst_lat_capture.sv | 51 +++++
 rtl/pst_trial_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pst_trial_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pst_seq_pkg.sv
// pst_seq_pkg
//   Shared definitions for the PST trial sequencer: FSM state codes,
//   the "no latency recorded" marker and the default parameter values.
//   No ports (package).
package pst_seq_pkg;

   // FSM state encoding, also driven out on the state debug port
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_TRAIN   = 3'd1;
   localparam logic [2:0] ST_MEASURE = 3'd2;
   localparam logic [2:0] ST_SETTLE  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Latency table entry that has not been written in this run
   localparam logic [7:0] NO_LAT = 8'hFF;

   // Default parameter values
   localparam int DEF_CUR_A      = 200;
   localparam int DEF_CUR_B      = 5;
   localparam int DEF_HOLD_CYC   = 10;
   localparam int DEF_TRAIN_SEGS = 4;
   localparam int DEF_N_TRIALS   = 6;
   localparam int DEF_MAX_CYC    = 10;
   localparam int DEF_ERR_TOL    = 5;

endpackage

// File: rtl/pst_lat_capture.sv
// pst_lat_capture
//   First-hit detector for one DUT during one measured trial. While arm is
//   high, the first sample strobe whose error is <= tol latches cyc as the
//   latency; later hits are ignored. Dropping arm clears the detector.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   arm          high while a trial is being measured
//   sample       one-clk strobe: error is valid for cycle number cyc
//   cyc          cycle number (1-based) that this sample belongs to
//   error, tol   measured error and convergence threshold
//   hit          a hit has been seen, including one on this very sample
//   latency      recorded (or just-detected) latency, NO_LAT if no hit
module pst_lat_capture
   import pst_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm,
   input  logic       sample,
   input  logic [7:0] cyc,
   input  logic [7:0] error,
   input  logic [7:0] tol,
   output logic       hit,
   output logic [7:0] latency
);

   logic       hit_q;
   logic [7:0] lat_q;
   logic       new_hit;

   assign new_hit = arm && sample && !hit_q && (error <= tol);

   // Combinational bypass so the caller can close a trial on the same clock
   // as a hit on its final sample.
   assign hit     = hit_q || new_hit;
   assign latency = hit_q ? lat_q : (new_hit ? cyc : NO_LAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q <= 1'b0;
         lat_q <= NO_LAT;
      end else if (!arm) begin
         hit_q <= 1'b0;
         lat_q <= NO_LAT;
      end else if (new_hit) begin
         hit_q <= 1'b1;
         lat_q <= cyc;
      end
   end

endmodule

// File: rtl/pst_trial_sequencer.sv
// pst_trial_sequencer
//   Drives a training current pattern into two DUTs, then runs N_TRIALS
//   measured transitions and records how many gamma cycles each DUT needs
//   to converge (error <= ERR_TOL). start and cycle_start are one-clock
//   strobes sampled on the rising clock edge; there is no backpressure.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cycle_start        gamma cycle boundary pulse; all counters step on it
//   start              run request, honoured only in IDLE or DONE
//   error_a, error_b   L2 error from DUT A (L3 active) / DUT B (L3 frozen)
//   rd_idx             latency table read index (0-based trial)
//   input_current      current driven to both DUTs
//   state              FSM state code (debug)
//   busy, done         high in TRAIN/MEASURE/SETTLE, high in DONE
//   lat_a, lat_b       latency of trial rd_idx, NO_LAT if out of range
//   a_faster_cnt       trials where DUT A converged strictly faster
module pst_trial_sequencer
   import pst_seq_pkg::*;
#(
   parameter int CUR_A      = DEF_CUR_A,
   parameter int CUR_B      = DEF_CUR_B,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int TRAIN_SEGS = DEF_TRAIN_SEGS,
   parameter int N_TRIALS   = DEF_N_TRIALS,
   parameter int MAX_CYC    = DEF_MAX_CYC,
   parameter int ERR_TOL    = DEF_ERR_TOL
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cycle_start,
   input  logic       start,
   input  logic [7:0] error_a,
   input  logic [7:0] error_b,
   input  logic [2:0] rd_idx,
   output logic [7:0] input_current,
   output logic [2:0] state,
   output logic       busy,
   output logic       done,
   output logic [7:0] lat_a,
   output logic [7:0] lat_b,
   output logic [3:0] a_faster_cnt
);

   logic [2:0] state_q;
   logic [7:0] cur_q;
   logic [7:0] seg_q;
   logic [7:0] cyc_q;
   logic [7:0] cyc_n;
   logic [2:0] k_q;
   logic [3:0] cnt_q;
   logic [7:0] tab_a [N_TRIALS];
   logic [7:0] tab_b [N_TRIALS];

   logic       measuring;
   logic       sample;
   logic       last_sample;
   logic       start_ok;
   logic       hit_a, hit_b;
   logic [7:0] cap_a, cap_b;
   logic [7:0] fin_a, fin_b;

   assign measuring   = (state_q == ST_MEASURE);
   assign sample      = measuring && cycle_start;
   assign cyc_n       = cyc_q + 8'd1;
   assign last_sample = sample && (cyc_q == 8'(MAX_CYC - 1));
   assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   pst_lat_capture u_cap_a (
      .clk(clk), .rst_n(rst_n), .arm(measuring), .sample(sample), .cyc(cyc_n),
      .error(error_a), .tol(8'(ERR_TOL)), .hit(hit_a), .latency(cap_a)
   );

   pst_lat_capture u_cap_b (
      .clk(clk), .rst_n(rst_n), .arm(measuring), .sample(sample), .cyc(cyc_n),
      .error(error_b), .tol(8'(ERR_TOL)), .hit(hit_b), .latency(cap_b)
   );

   // A DUT that never converged inside the window is charged the full window
   assign fin_a = hit_a ? cap_a : 8'(MAX_CYC);
   assign fin_b = hit_b ? cap_b : 8'(MAX_CYC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cur_q   <= 8'd0;
         seg_q   <= 8'd0;
         cyc_q   <= 8'd0;
         k_q     <= 3'd0;
         cnt_q   <= 4'd0;
         for (int i = 0; i < N_TRIALS; i++) begin
            tab_a[i] <= NO_LAT;
            tab_b[i] <= NO_LAT;
         end
      end else if (start_ok) begin
         // start wins over a coincident cycle_start, which is not counted
         state_q <= ST_TRAIN;
         cur_q   <= 8'(CUR_A);
         seg_q   <= 8'd0;
         cyc_q   <= 8'd0;
         k_q     <= 3'd0;
         cnt_q   <= 4'd0;
         for (int i = 0; i < N_TRIALS; i++) begin
            tab_a[i] <= NO_LAT;
            tab_b[i] <= NO_LAT;
         end
      end else if (cycle_start) begin
         case (state_q)
            ST_TRAIN: begin
               if (cyc_q == 8'(HOLD_CYC - 1)) begin
                  cyc_q <= 8'd0;
                  if (seg_q == 8'(TRAIN_SEGS - 1)) begin
                     state_q <= ST_MEASURE;
                     k_q     <= 3'd0;
                     cur_q   <= 8'(CUR_A);
                  end else begin
                     seg_q <= seg_q + 8'd1;
                     // even segments carry A, odd segments carry B
                     cur_q <= seg_q[0] ? 8'(CUR_A) : 8'(CUR_B);
                  end
               end else begin
                  cyc_q <= cyc_n;
               end
            end
            ST_MEASURE: begin
               if (last_sample) begin
                  tab_a[k_q] <= fin_a;
                  tab_b[k_q] <= fin_b;
                  if ((fin_a < fin_b) && (cnt_q < 4'(N_TRIALS)))
                     cnt_q <= cnt_q + 4'd1;
                  state_q <= ST_SETTLE;
                  cyc_q   <= 8'd0;
               end else begin
                  cyc_q <= cyc_n;
               end
            end
            ST_SETTLE: begin
               if (cyc_q == 8'(HOLD_CYC - 1)) begin
                  cyc_q <= 8'd0;
                  if (k_q == 3'(N_TRIALS - 1)) begin
                     state_q <= ST_DONE;
                  end else begin
                     k_q     <= k_q + 3'd1;
                     state_q <= ST_MEASURE;
                     // trial k+1 uses A when k+1 is even
                     cur_q   <= k_q[0] ? 8'(CUR_A) : 8'(CUR_B);
                  end
               end else begin
                  cyc_q <= cyc_n;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      lat_a = NO_LAT;
      lat_b = NO_LAT;
      if ({1'b0, rd_idx} < 4'(N_TRIALS)) begin
         lat_a = tab_a[rd_idx];
         lat_b = tab_b[rd_idx];
      end
   end

   assign input_current = cur_q;
   assign state         = state_q;
   assign busy          = (state_q == ST_TRAIN) || (state_q == ST_MEASURE) ||
                          (state_q == ST_SETTLE);
   assign done          = (state_q == ST_DONE);
   assign a_faster_cnt  = cnt_q;

endmodule

// File: tb/tb_pst_trial_sequencer.sv
// tb_pst_trial_sequencer
//   Directed bench for pst_trial_sequencer with a queue-based scoreboard.
//   The driver pushes hand-computed expectations; a negedge monitor pops
//   them and compares against the selected DUT output.
module tb_pst_trial_sequencer;
   import pst_seq_pkg::*;

   localparam int K_STATE = 0;
   localparam int K_CUR   = 1;
   localparam int K_BUSY  = 2;
   localparam int K_DONE  = 3;
   localparam int K_LATA  = 4;
   localparam int K_LATB  = 5;
   localparam int K_CNT   = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cycle_start = 1'b0;
   logic       start = 1'b0;
   logic [7:0] error_a = 8'd0;
   logic [7:0] error_b = 8'd0;
   logic [2:0] rd_idx = 3'd0;
   logic [7:0] input_current;
   logic [2:0] state;
   logic       busy;
   logic       done;
   logic [7:0] lat_a;
   logic [7:0] lat_b;
   logic [3:0] a_faster_cnt;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   pst_trial_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cycle_start(cycle_start), .start(start),
      .error_a(error_a), .error_b(error_b), .rd_idx(rd_idx),
      .input_current(input_current), .state(state), .busy(busy), .done(done),
      .lat_a(lat_a), .lat_b(lat_b), .a_faster_cnt(a_faster_cnt)
   );

   // ---------------- hand-computed trial tables ----------------
   // cycle at which each DUT first reaches error <= 5 (0 = never)
   int         hit_a_cyc [6] = '{2, 10, 0, 1, 7, 3};
   int         hit_b_cyc [6] = '{4,  0, 1, 3, 7, 0};
   logic [7:0] exp_la    [6] = '{8'd2, 8'd10, 8'd10, 8'd1, 8'd7, 8'd3};
   logic [7:0] exp_lb    [6] = '{8'd4, 8'd10, 8'd1, 8'd3, 8'd7, 8'd10};
   logic [3:0] exp_cnt   [6] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
   logic [7:0] exp_cur   [6] = '{8'd200, 8'd5, 8'd200, 8'd5, 8'd200, 8'd5};

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q  [$];
   int         kind_q [$];
   string      name_q [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         period = 256;

   function automatic logic [7:0] observe(input int kind);
      case (kind)
         K_STATE: return {5'd0, state};
         K_CUR:   return input_current;
         K_BUSY:  return {7'd0, busy};
         K_DONE:  return {7'd0, done};
         K_LATA:  return lat_a;
         K_LATB:  return lat_b;
         K_CNT:   return {4'd0, a_faster_cnt};
         default: return 8'hXX;
      endcase
   endfunction

   logic [7:0] mon_exp;
   logic [7:0] mon_act;
   int         mon_kind;
   string      mon_name;

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_kind = kind_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = observe(mon_kind);
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", mon_name, mon_act, mon_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One expectation per clock so rd_idx is stable when the monitor samples.
   task automatic expect_val(input int kind, input int idx, input logic [7:0] val,
                             input string name);
      rd_idx = 3'(idx);
      exp_q.push_back(val);
      kind_q.push_back(kind);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   task automatic gamma(input logic [7:0] ea, input logic [7:0] eb);
      error_a     = ea;
      error_b     = eb;
      cycle_start = 1'b1;
      @(posedge clk);
      #1;
      cycle_start = 1'b0;
      repeat (period - 1) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] err_val(input int h, input int n);
      if (h != 0 && n == h) return 8'd5;  // exactly at the threshold
      if (h != 0 && n > h)  return 8'd0;  // later hits must be ignored
      return 8'd6;                        // just above the threshold
   endfunction

   task automatic run_trial(input int t, input bit chk);
      for (int n = 1; n <= 10; n++) begin
         gamma(err_val(hit_a_cyc[t], n), err_val(hit_b_cyc[t], n));
         if (chk && t == 0 && n == 3) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            expect_val(K_STATE, 0, 8'd2, "start_ignored_in_measure");
            expect_val(K_CUR, 0, 8'd200, "cur_after_ignored_start");
         end
      end
      if (chk) begin
         expect_val(K_STATE, 0, 8'd3, "settle_after_trial");
         expect_val(K_CUR, 0, exp_cur[t], "cur_held_in_settle");
         expect_val(K_LATA, t, exp_la[t], $sformatf("lat_a_%0d", t));
         expect_val(K_LATB, t, exp_lb[t], $sformatf("lat_b_%0d", t));
         expect_val(K_CNT, 0, {4'd0, exp_cnt[t]}, $sformatf("a_faster_cnt_%0d", t));
      end
      for (int n = 1; n <= 10; n++) begin
         gamma(8'd0, 8'd0);
         if (chk && t == 5 && n == 9)
            expect_val(K_DONE, 0, 8'd0, "not_done_before_last_settle");
      end
      if (chk && t < 5) begin
         expect_val(K_STATE, 0, 8'd2, "measure_next_trial");
         expect_val(K_CUR, 0, exp_cur[t+1], "cur_next_trial");
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      expect_val(K_STATE, 0, 8'd0, "reset_state");
      expect_val(K_CUR, 0, 8'd0, "reset_cur");
      expect_val(K_BUSY, 0, 8'd0, "reset_busy");
      expect_val(K_DONE, 0, 8'd0, "reset_done");
      expect_val(K_CNT, 0, 8'd0, "reset_cnt");
      expect_val(K_LATA, 0, 8'hFF, "reset_lat_a0");
      expect_val(K_LATB, 5, 8'hFF, "reset_lat_b5");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Run 1: start coincident with cycle_start, which must not be counted
      period      = 256;
      start       = 1'b1;
      cycle_start = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      cycle_start = 1'b0;
      repeat (period - 1) @(posedge clk);
      #1;
      expect_val(K_STATE, 0, 8'd1, "train_entry_state");
      expect_val(K_CUR, 0, 8'd200, "train_entry_cur");
      expect_val(K_BUSY, 0, 8'd1, "train_busy");
      expect_val(K_CNT, 0, 8'd0, "train_cnt");

      for (int g = 1; g <= 40; g++) begin
         gamma(8'd0, 8'd0);
         case (g)
            9:  expect_val(K_CUR, 0, 8'd200, "seg0_after_9");
            10: expect_val(K_CUR, 0, 8'd5, "seg1_cur");
            20: expect_val(K_CUR, 0, 8'd200, "seg2_cur");
            30: expect_val(K_CUR, 0, 8'd5, "seg3_cur");
            39: expect_val(K_STATE, 0, 8'd1, "still_train_39");
            40: begin
               expect_val(K_STATE, 0, 8'd2, "measure_entry_state");
               expect_val(K_CUR, 0, 8'd200, "measure_entry_cur");
            end
            default: ;
         endcase
      end

      for (int t = 0; t < 6; t++) run_trial(t, 1'b1);

      expect_val(K_STATE, 0, 8'd4, "done_state");
      expect_val(K_DONE, 0, 8'd1, "done_flag");
      expect_val(K_BUSY, 0, 8'd0, "done_not_busy");
      expect_val(K_CUR, 0, 8'd5, "done_cur_held");
      for (int i = 0; i < 6; i++) begin
         expect_val(K_LATA, i, exp_la[i], $sformatf("final_lat_a_%0d", i));
         expect_val(K_LATB, i, exp_lb[i], $sformatf("final_lat_b_%0d", i));
      end
      expect_val(K_LATA, 6, 8'hFF, "lat_a_idx6");
      expect_val(K_LATB, 6, 8'hFF, "lat_b_idx6");
      expect_val(K_LATA, 7, 8'hFF, "lat_a_idx7");
      expect_val(K_LATB, 7, 8'hFF, "lat_b_idx7");
      gamma(8'd0, 8'd0);
      gamma(8'd0, 8'd0);
      expect_val(K_STATE, 0, 8'd4, "done_stays");
      expect_val(K_CNT, 0, 8'd3, "done_cnt_held");

      // Run 2: restart from DONE, then reset during trial 3
      period = 16;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      expect_val(K_STATE, 0, 8'd1, "restart_state");
      expect_val(K_CUR, 0, 8'd200, "restart_cur");
      expect_val(K_CNT, 0, 8'd0, "restart_cnt");
      expect_val(K_LATA, 0, 8'hFF, "restart_lat_a0");
      expect_val(K_LATB, 3, 8'hFF, "restart_lat_b3");

      for (int g = 1; g <= 40; g++) gamma(8'd0, 8'd0);
      for (int t = 0; t < 3; t++) run_trial(t, 1'b0);
      expect_val(K_LATA, 2, 8'd10, "run2_lat_a2");
      expect_val(K_CNT, 0, 8'd1, "run2_cnt");
      for (int n = 1; n <= 4; n++)
         gamma(err_val(hit_a_cyc[3], n), err_val(hit_b_cyc[3], n));
      expect_val(K_STATE, 0, 8'd2, "trial3_measuring");

      #2;
      rst_n = 1'b0;  // mid-cycle; monitor samples before the next rising edge
      expect_val(K_STATE, 0, 8'd0, "async_reset_state");
      expect_val(K_CUR, 0, 8'd0, "async_reset_cur");
      expect_val(K_BUSY, 0, 8'd0, "async_reset_busy");
      expect_val(K_CNT, 0, 8'd0, "async_reset_cnt");
      for (int i = 0; i < 4; i++)
         expect_val(K_LATA, i, 8'hFF, $sformatf("reset_clear_lat_a_%0d", i));
      expect_val(K_LATB, 2, 8'hFF, "reset_clear_lat_b2");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      gamma(8'd0, 8'd0);
      expect_val(K_STATE, 0, 8'd0, "idle_ignores_cycle_start");
      expect_val(K_CUR, 0, 8'd0, "idle_cur");

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
